// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, LSB first, one bit per clock.
// Optional signed-overflow output (port ovf) is built when SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last completed operation
// SHIFT | one operand bit pair consumed per clock through the full-subtractor cell
// DONE  | one-cycle done pulse; result outputs were updated on the entering edge
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             bout;
  logic [WIDTH-1:0] res_final;

`ifdef SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  assign accept    = (state == IDLE) && start;
  assign last_bit  = (cnt == LAST);

  // full-subtractor cell
  assign d_bit     = a_sr[0] ^ b_sr[0] ^ bin;
  assign bout      = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bin);

  // the minuend register doubles as the result register: each consumed
  // minuend bit frees the MSB slot that receives the new difference bit
  assign res_final = {d_bit, a_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr <= res_final;
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      bin  <= bout;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff       <= res_final;
        borrow_out <= bout;
        zero       <= ~|res_final;
      end
    end
  end

`ifdef SUB_OVF_EN
  // overflow only when operand signs differ and the result sign differs from A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == SHIFT) && last_bit) begin
      ovf <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus random
// operands compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
`ifdef SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; inject_at > 0 pulses a competing start during SHIFT.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int inject_at);
    int           sd;
    int           n;
    int           busy_n;
    logic [W-1:0] ed;
    logic         eb;
    logic         ez;
    logic         eo;
    logic         hold_ok;
    ed = W'(int'(av) - int'(bv));
    eb = (int'(av) < int'(bv));
    ez = (ed == '0);
    sd = int'($signed(av)) - int'($signed(bv));
    eo = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));

    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 1;
    busy_n = 0;
    hold_ok = 1'b1;
    while (done !== 1'b1 && n <= W + 4) begin
      if (busy === 1'b1) busy_n++;
      if (diff !== last_diff) hold_ok = 1'b0;
      if (n == inject_at) begin
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_busy_cycles"}, busy_n, W);
    check({tag, "_hold_prev"}, hold_ok, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow_out, eb);
    check({tag, "_zero"}, zero, ez);
`ifdef SUB_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`endif
    last_diff = ed;
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_diff_hold"}, diff, ed);
  endtask

  initial begin
    int extra_done;
    #2;
    check("reset_state", {busy, done, diff, borrow_out, zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("t1_5a_3c", 8'h5A, 8'h3C, 0);
    do_op("t2_00_01", 8'h00, 8'h01, 0);
    do_op("t3_77_77", 8'h77, 8'h77, 0);
    do_op("t3_10_01", 8'h10, 8'h01, 0);

    do_op("t4_ignore", 8'h42, 8'h13, 3);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    check("t4_no_second_op", extra_done, 0);

    // reset in the middle of SHIFT
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {busy, done, diff, borrow_out, zero}, '0);
`ifdef SUB_OVF_EN
    check("t5_rst_ovf", ovf, 1'b0);
`endif
    extra_done = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    rst_n = 1'b1;
    last_diff = '0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    check("t5_no_done_after_abort", extra_done, 0);
    do_op("t5_09_03", 8'h09, 8'h03, 0);

    do_op("t6_80_01", 8'h80, 8'h01, 0);
    do_op("t6_05_03", 8'h05, 8'h03, 0);
    do_op("edge_7f_ff", 8'h7F, 8'hFF, 0);
    do_op("edge_ff_ff", 8'hFF, 8'hFF, 0);
    do_op("edge_00_80", 8'h00, 8'h80, 0);

    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
